// File: rtl/spi_px_master.sv
// SPI mode-0 master that shifts one PX_BITS pixel word out MSB first and captures the slave word in the same frame.
// A frame is a setup phase, PX_BITS SCK periods and an inter-frame gap. New words are accepted only while idle.
module spi_px_master #(
    parameter int PX_BITS = 24,
    parameter int CLK_DIV = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               px_valid_i,
    input  logic [PX_BITS-1:0] px_data_i,
    output logic               px_ready_o,
    output logic [PX_BITS-1:0] rx_data_o,
    output logic               rx_valid_o,
    output logic               busy_o,
    output logic               spi_cs_o,
    output logic               spi_sck_o,
    output logic               spi_sdo_o,
    input  logic               spi_sdi_i
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (PX_BITS > 2) ? $clog2(PX_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PX_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    // sdo_q is the MSB stage of the TX word; tx_sr_q holds the bits not yet presented
    logic [PX_BITS-2:0] tx_sr_q;
    logic [PX_BITS-1:0] rx_sr_q;
    logic [PX_BITS-1:0] rx_data_q;
    logic               cs_q, sck_q, sdo_q, rx_valid_q;
    logic               accept, div_done, last_bit;

    assign px_ready_o = (state_q == IDLE) && !reset_i;
    assign accept     = px_valid_i && px_ready_o;
    assign div_done   = (div_cnt_q == DIV_LAST);
    assign last_bit   = (bit_cnt_q == BIT_LAST);

    assign busy_o     = (state_q != IDLE);
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign spi_cs_o   = cs_q;
    assign spi_sck_o  = sck_q;
    assign spi_sdo_o  = sdo_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (div_done) state_d = SHIFT;
            SHIFT:   if (div_done && !sck_q && last_bit) state_d = GAP;
            GAP:     if (div_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            sdo_q      <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q == IDLE || div_done) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tx_sr_q   <= px_data_i[PX_BITS-2:0];
                        sdo_q     <= px_data_i[PX_BITS-1];
                        cs_q      <= 1'b0;
                        bit_cnt_q <= '0;
                        rx_sr_q   <= '0;
                    end
                end
                SETUP: begin
                    if (div_done) begin
                        sck_q   <= 1'b1;
                        rx_sr_q <= {rx_sr_q[PX_BITS-2:0], spi_sdi_i};
                    end
                end
                SHIFT: begin
                    if (div_done) begin
                        if (sck_q) begin
                            sck_q <= 1'b0;
                            // the last bit stays on SDO until CS rises
                            if (!last_bit) begin
                                sdo_q   <= tx_sr_q[PX_BITS-2];
                                tx_sr_q <= tx_sr_q << 1;
                            end
                        end else if (last_bit) begin
                            cs_q       <= 1'b1;
                            sdo_q      <= 1'b0;
                            rx_data_q  <= rx_sr_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            sck_q     <= 1'b1;
                            rx_sr_q   <= {rx_sr_q[PX_BITS-2:0], spi_sdi_i};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_px_master.sv
// Randomised scoreboard bench for spi_px_master: driver queues expected TX/RX words, a monitor checks pins and results.
module tb_spi_px_master;

    localparam int PX  = 24;
    localparam int DIV = 4;
    localparam int CS_LOW = DIV * (1 + 2 * PX);

    logic          clk = 1'b0;
    logic          reset_i;
    logic          px_valid;
    logic [PX-1:0] px_data;
    logic          px_ready_o;
    logic [PX-1:0] rx_data_o;
    logic          rx_valid_o;
    logic          busy_o;
    logic          spi_cs_o;
    logic          spi_sck_o;
    logic          spi_sdo_o;
    logic          spi_sdi;

    // 0: loopback, 1: SDI tied high, 2: behavioural slave shifting slave_word
    int            sdi_mode = 0;
    logic [PX-1:0] slave_word = '0;
    int            slave_idx = 0;
    logic          slave_prev_sck = 1'b0;

    typedef struct {
        logic [PX-1:0] word;
        bit            b2b;
    } tx_t;

    tx_t           tx_q[$];
    logic [PX-1:0] rx_q[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign spi_sdi = (sdi_mode == 0) ? spi_sdo_o :
                     (sdi_mode == 1) ? 1'b1 :
                     (slave_idx < PX) ? slave_word[PX-1-slave_idx] : 1'b0;

    spi_px_master #(.PX_BITS(PX), .CLK_DIV(DIV)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .px_valid_i (px_valid),
        .px_data_i  (px_data),
        .px_ready_o (px_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .busy_o     (busy_o),
        .spi_cs_o   (spi_cs_o),
        .spi_sck_o  (spi_sck_o),
        .spi_sdo_o  (spi_sdo_o),
        .spi_sdi_i  (spi_sdi)
    );

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave model: presents the next bit after every SCK fall, first bit when CS goes low
    always @(negedge clk) begin
        if (spi_cs_o) slave_idx = 0;
        else if (slave_prev_sck && !spi_sck_o) slave_idx = slave_idx + 1;
        slave_prev_sck = spi_sck_o;
    end

    function automatic logic [PX-1:0] model_rx(input logic [PX-1:0] w);
        if (sdi_mode == 0) return w;
        if (sdi_mode == 1) return '1;
        return slave_word;
    endfunction

    // Monitor
    int            cyc = 0;
    bit            prev_cs = 1'b1;
    bit            prev_sck = 1'b0;
    bit            in_frame = 1'b0;
    bit            seen_rise = 1'b0;
    int            last_rise = 0;
    int            low_cnt = 0;
    int            rise_cnt = 0;
    tx_t           cur;
    logic [PX-1:0] last_rx = '0;
    logic [PX-1:0] exp_rx;

    always @(negedge clk) begin
        cyc++;
        if (reset_i) begin
            in_frame  = 1'b0;
            seen_rise = 1'b0;
            prev_cs   = 1'b1;
            prev_sck  = 1'b0;
            last_rx   = '0;
        end else begin
            if (spi_cs_o) begin
                if (spi_sdo_o !== 1'b0) chk(0, "sdo_idle", 32'(spi_sdo_o), 0);
                if (spi_sck_o !== 1'b0) chk(0, "sck_idle", 32'(spi_sck_o), 0);
            end else begin
                chk(px_ready_o === 1'b0, "ready_in_frame", 32'(px_ready_o), 0);
                chk(busy_o === 1'b1, "busy_in_frame", 32'(busy_o), 1);
            end
            if (prev_cs && !spi_cs_o) begin
                if (tx_q.size() == 0) begin
                    chk(0, "unexpected_frame", 1, 0);
                end else begin
                    cur      = tx_q.pop_front();
                    in_frame = 1'b1;
                    low_cnt  = 0;
                    rise_cnt = 0;
                    if (seen_rise) chk(cyc - last_rise >= DIV + 1, "cs_gap_min", 32'(cyc - last_rise), DIV + 1);
                    if (cur.b2b) chk(cyc - last_rise == DIV + 1, "cs_gap_b2b", 32'(cyc - last_rise), DIV + 1);
                end
            end
            if (!spi_cs_o && in_frame) begin
                low_cnt++;
                if (!prev_sck && spi_sck_o) begin
                    if (rise_cnt < PX)
                        chk(spi_sdo_o === cur.word[PX-1-rise_cnt], "sdo_bit", 32'(spi_sdo_o), 32'(cur.word[PX-1-rise_cnt]));
                    rise_cnt++;
                end
            end
            if (!prev_cs && spi_cs_o && in_frame) begin
                chk(low_cnt == CS_LOW, "cs_low_cycles", 32'(low_cnt), CS_LOW);
                chk(rise_cnt == PX, "sck_rises", 32'(rise_cnt), PX);
                in_frame  = 1'b0;
                seen_rise = 1'b1;
                last_rise = cyc;
            end
            if (rx_valid_o) begin
                chk(!prev_cs && spi_cs_o, "rxv_on_cs_rise", 32'(spi_cs_o), 1);
                if (rx_q.size() == 0) begin
                    chk(0, "unexpected_rx_valid", 32'(rx_data_o), 0);
                end else begin
                    exp_rx = rx_q.pop_front();
                    chk(rx_data_o === exp_rx, "rx_data", 32'(rx_data_o), 32'(exp_rx));
                end
                last_rx = rx_data_o;
            end else if (rx_data_o !== last_rx) begin
                chk(0, "rx_hold", 32'(rx_data_o), 32'(last_rx));
            end
            prev_cs  = spi_cs_o;
            prev_sck = spi_sck_o;
        end
    end

    task automatic send(input logic [PX-1:0] w, input bit push_rx, input bit b2b);
        int budget = 2000;
        @(negedge clk);
        px_valid = 1'b1;
        px_data  = w;
        while (!px_ready_o && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!px_ready_o) begin
            chk(0, "accept_timeout", 0, 1);
            return;
        end
        tx_q.push_back('{w, b2b});
        if (push_rx) rx_q.push_back(model_rx(w));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int budget = 2000;
        @(negedge clk);
        while (busy_o && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (busy_o) chk(0, "idle_timeout", 32'(busy_o), 0);
    endtask

    initial begin
        int       n;
        int       budget;
        bit       ps;
        logic [PX-1:0] w;

        reset_i  = 1'b0;
        px_valid = 1'b0;
        px_data  = '0;
        #2 reset_i = 1'b1;
        #2;
        chk(spi_cs_o === 1'b1, "rst_cs", 32'(spi_cs_o), 1);
        chk(spi_sck_o === 1'b0, "rst_sck", 32'(spi_sck_o), 0);
        chk(spi_sdo_o === 1'b0, "rst_sdo", 32'(spi_sdo_o), 0);
        chk(px_ready_o === 1'b0, "rst_ready", 32'(px_ready_o), 0);
        chk(busy_o === 1'b0, "rst_busy", 32'(busy_o), 0);
        chk(rx_valid_o === 1'b0, "rst_rxv", 32'(rx_valid_o), 0);
        chk(rx_data_o === '0, "rst_rxdata", 32'(rx_data_o), 0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk(px_ready_o === 1'b1, "ready_after_rst", 32'(px_ready_o), 1);

        // loopback of a known word
        sdi_mode = 0;
        send(24'hA5C3F0, 1, 0);
        px_valid = 1'b0;
        wait_idle();

        // SDI high, all-zero word
        sdi_mode = 1;
        send(24'h000000, 1, 0);
        px_valid = 1'b0;
        wait_idle();

        // valid held high across two words
        sdi_mode = 0;
        send(24'h123456, 1, 0);
        send(24'h654321, 1, 1);
        px_valid = 1'b0;
        wait_idle();

        // valid pulse in the middle of a frame must be ignored
        send(24'h3C3C3C, 1, 0);
        px_valid = 1'b0;
        repeat (60) @(negedge clk);
        px_valid = 1'b1;
        px_data  = 24'hDEAD01;
        @(negedge clk);
        px_valid = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);

        // randomised frames across all SDI sources
        for (int i = 0; i < 10; i++) begin
            sdi_mode   = int'($urandom_range(0, 2));
            slave_word = PX'($urandom);
            w          = PX'($urandom);
            send(w, 1, 0);
            px_valid = 1'b0;
            wait_idle();
        end

        // asynchronous reset after 10 SCK rises aborts the frame
        sdi_mode = 0;
        send(24'h5A5A5A, 0, 0);
        px_valid = 1'b0;
        n = 0;
        ps = 1'b0;
        budget = 1000;
        while (n < 10 && budget > 0) begin
            @(negedge clk);
            if (!ps && spi_sck_o) n++;
            ps = spi_sck_o;
            budget--;
        end
        chk(n == 10, "sck_rise_wait", 32'(n), 10);
        @(posedge clk);
        #3 reset_i = 1'b1;
        #1;
        chk(spi_cs_o === 1'b1, "abort_cs", 32'(spi_cs_o), 1);
        chk(spi_sck_o === 1'b0, "abort_sck", 32'(spi_sck_o), 0);
        chk(spi_sdo_o === 1'b0, "abort_sdo", 32'(spi_sdo_o), 0);
        chk(rx_valid_o === 1'b0, "abort_rxv", 32'(rx_valid_o), 0);
        chk(rx_data_o === '0, "abort_rxdata", 32'(rx_data_o), 0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk(px_ready_o === 1'b1, "ready_after_abort", 32'(px_ready_o), 1);
        chk(busy_o === 1'b0, "idle_after_abort", 32'(busy_o), 0);
        tx_q.delete();

        // one more loopback frame after the abort
        send(24'h0F1E2D, 1, 0);
        px_valid = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);

        chk(tx_q.size() == 0, "tx_drain", 32'(tx_q.size()), 0);
        chk(rx_q.size() == 0, "rx_drain", 32'(rx_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_px_master.md
SPI_PX_MASTER -- requirements
Module: spi_px_master

Interface
REQ-001 Parameter PX_BITS, default 24: frame length in bits (one pixel word), MSB first.
REQ-002 Parameter CLK_DIV, default 4: SCK half-period in clk_i cycles; legal range 4..255.
REQ-003 Port clk_i  in  1  single system clock; all logic is on the rising edge.
REQ-004 Port reset_i  in  1  reset, asynchronous and active-high.
REQ-005 Port px_valid_i  in  1  a pixel word is offered for transmission.
REQ-006 Port px_data_i  in  PX_BITS  pixel word to shift out.
REQ-007 Port px_ready_o  out  1  the block accepts px_data_i this cycle.
REQ-008 Port rx_data_o  out  PX_BITS  word captured from the slave during the last completed frame.
REQ-009 Port rx_valid_o  out  1  one-cycle pulse: rx_data_o was updated.
REQ-010 Port busy_o  out  1  a frame or the inter-frame gap is in progress.
REQ-011 Port spi_cs_o  out  1  chip select, active-low.
REQ-012 Port spi_sck_o  out  1  serial clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 Port spi_sdo_o  out  1  master-out data, driven to the slave SDI.
REQ-014 Port spi_sdi_i  in  1  master-in data from the slave SDO.

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP, SHIFT and GAP.
REQ-016 IDLE: px_ready_o=1, busy_o=0, spi_cs_o=1, spi_sck_o=0.
REQ-017 A transfer is accepted when px_valid_i and px_ready_o are both 1 on a clk_i edge: px_data_i is latched into the TX shift register and the FSM enters SETUP.
REQ-018 px_ready_o SHALL be 0 in every state other than IDLE; px_valid_i outside IDLE is ignored and has no effect.
REQ-019 SETUP lasts CLK_DIV cycles:
- spi_cs_o=0, spi_sck_o=0
- spi_sdo_o = TX MSB
REQ-020 SHIFT generates PX_BITS SCK periods. Each period is CLK_DIV cycles high followed by CLK_DIV cycles low.
REQ-021 On each SCK rising transition, spi_sdi_i SHALL be sampled into the LSB of the RX shift register, which shifts left.
REQ-022 On each SCK falling transition except the last, the TX register SHALL shift left so that spi_sdo_o presents the next bit.
REQ-023 After the low phase of the PX_BITS-th period completes, the following happen on the same edge:
- spi_cs_o returns to 1
- rx_data_o is loaded from the RX register
- rx_valid_o pulses for exactly one cycle
- the FSM enters GAP.
REQ-024 spi_cs_o SHALL be low for exactly CLK_DIV*(1+2*PX_BITS) cycles per frame (196 cycles at the defaults).
REQ-025 GAP lasts CLK_DIV cycles with spi_cs_o=1 and spi_sck_o=0, then the FSM returns to IDLE. The minimum CS-high time between frames is therefore CLK_DIV+1 cycles.
REQ-026 rx_data_o SHALL hold its value until the next frame completes.
REQ-027 spi_sdo_o SHALL be 0 whenever spi_cs_o=1.
REQ-028 spi_cs_o, spi_sck_o and spi_sdo_o SHALL each be driven directly from a flop, with no combinational path to the pins.
REQ-029 The divider counter and the bit counter SHALL be sized to hold CLK_DIV-1 and PX_BITS-1 respectively. They SHALL wrap with no overflow beyond those values.

Reset
REQ-030 While reset_i=1, regardless of clk_i, the block SHALL immediately force:
- FSM=IDLE
- spi_cs_o=1, spi_sck_o=0, spi_sdo_o=0
- rx_valid_o=0, busy_o=0
- rx_data_o=0, all counters and shift registers =0
- px_ready_o=0
REQ-031 A reset asserted mid-frame SHALL abort the frame. No rx_valid_o pulse is produced and the partial RX data is discarded.
REQ-032 In the first cycle after reset_i deasserts, the block SHALL be in IDLE with px_ready_o=1.

Verification
REQ-033 Loopback (spi_sdi_i tied to spi_sdo_o), defaults, send 0xA5C3F0 -> 24 SCK rising edges observed; rx_data_o=0xA5C3F0 with a single rx_valid_o pulse on the CS-rise cycle; CS low for 196 cycles.
REQ-034 spi_sdi_i tied to 1, send 0x000000 -> spi_sdo_o=0 throughout the frame; rx_data_o=0xFFFFFF.
REQ-035 px_valid_i held high with two words, 0x123456 then 0x654321 -> both transmitted in order; the second CS fall occurs exactly 5 cycles after the first CS rise; px_ready_o=0 during both frames.
REQ-036 Assert reset_i asynchronously (not aligned to clk_i) after 10 SCK rising edges -> spi_cs_o=1 and spi_sck_o=0 before the next clk_i edge; no rx_valid_o pulse; px_ready_o=1 one cycle after release.
REQ-037 px_valid_i pulsed mid-frame -> ignored: the frame and its timing are unchanged and no extra frame is sent.
REQ-038 Connect to the existing SPI slave pixel path with CLK_DIV=4 -> a frame sent through the gray/sobel core returns the processed pixel on rx_data_o in a subsequent frame.
